pattern_scan_ctrl: RTL and testbench
====================================

Name: pattern_scan_ctrl

Overview:
Two-requester scheduler and sequencer for the shared bit-serial "1101" Moore sequence detector.
- Arbitrates round-robin between two word-sized requesters.
- Serializes the granted word MSB-first onto the detector input and counts detector hits.
- Flushes the detector so no state carries between words, then returns the hit count and requester ID over a valid/ready result port.

Parameters:
WIDTH, 8, data word width in bits (must be ≥4)
CNT_W, $clog2(WIDTH+1), width of the hit counter / result count

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset; same net drives the detector's n_rst
req0_valid  input  1  requester 0 has a word
req0_data  input  WIDTH  requester 0 word
req0_ready  output  1  requester 0 word accepted this cycle
req1_valid  input  1  requester 1 has a word
req1_data  input  WIDTH  requester 1 word
req1_ready  output  1  requester 1 word accepted this cycle
det_i  output  1  serial bit to detector input i
det_o  input  1  detector Moore output o
res_valid  output  1  result available
res_id  output  1  requester that owns the result
res_count  output  CNT_W  number of detections in the word
res_ready  input  1  result consumer accepts
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, n_rst=0) forces:
  - state=IDLE, det_i=0, res_valid=0, res_id=0, res_count=0, busy=0, reqN_ready=0.
  - Shift register=0, bit counter=0, hit counter=0.
  - last_grant=1, so requester 0 wins first.
- Reset mid-operation aborts the word with no result; the detector resets on the same edge.
- Detector timing: det_i is driven in cycle k and captured at the end of cycle k. A hit completed by that bit shows on det_o in cycle k+1.
- IDLE:
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational: high only in IDLE for the granted requester in that cycle.
  - On the grant edge: latch data into the shift register, record the ID, update last_grant, clear the hit and bit counters, go to SHIFT.
  - With no valid request, stay in IDLE.
- SHIFT (WIDTH cycles, bit counter 0..WIDTH-1):
  - det_i = shift register MSB; shift left by 1 each cycle.
  - When bit counter ≥1 and det_o=1, increment the hit counter.
  - After bit WIDTH-1, go to FLUSH.
- FLUSH (exactly 2 cycles):
  - det_i=0.
  - In the first FLUSH cycle, sample det_o for the last data bit and increment on a hit.
  - Two zeros return the detector to its idle state from any state, so the next word starts clean.
  - After 2 cycles, go to DONE.
- DONE:
  - res_valid=1; res_id and res_count are stable until the handshake.
  - On res_valid&res_ready, go to IDLE.
  - A new grant is possible the cycle after the handshake.
  - No new words are accepted while busy.
- Latency: grant edge at cycle 0 → res_valid first high at cycle WIDTH+3 (cycle 11 for WIDTH=8).
- Minimum throughput: one word per WIDTH+4 cycles.
- Hit counter saturates at 2^CNT_W−1. This is unreachable for legal WIDTH but required.
- Overlapping hits count as separate hits, e.g. 1101101 → 2.
- Undefined states decode to IDLE.

Test Plan:
- Reset, then req0 sends 8'b11011010 → req0_ready pulses at cycle 0; det_i follows 1,1,0,1,1,0,1,0,0,0; res_valid at cycle 11 with res_id=0, res_count=2.
- req0 sends 8'b00000000 → res_count=0. Then req0 sends 8'b11010000 → res_count=1.
- After reset, req0_valid and req1_valid are held high with different words → req0 is served first, req1 second, req0 third (alternating grants).
- Word 8'b00000011 followed by 8'b01000000 → both counts are 0, which proves the flush gives cross-word isolation.
- res_ready held low 5 cycles in DONE → res_valid, res_id and res_count stay stable and req*_ready stays 0; on release the block returns to IDLE the next cycle.
- Assert n_rst low during SHIFT bit 4 → all outputs return to reset values immediately; after release, a new req1 word is processed correctly from IDLE.

Source files
------------

// File: rtl/pattern_scan_ctrl.sv
// Round-robin two-requester front end for a shared bit-serial "1101" Moore detector.
// Each granted word is shifted MSB-first, then flushed; the hit count is returned over valid/ready.
module pattern_scan_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             det_i,
  input  logic             det_o,
  output logic             res_valid,
  output logic             res_id,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready,
  output logic             busy
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StShift, StFlush, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt0, gnt1, hit_inc;

  // last_grant_q = 1 means requester 0 has priority on a tie.
  assign gnt0 = req0_valid & (~req1_valid | last_grant_q);
  assign gnt1 = req1_valid & (~req0_valid | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    hit_d        = hit_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    hit_inc      = 1'b0;
    det_i        = 1'b0;
    res_valid    = 1'b0;
    busy         = 1'b1;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      StIdle: begin
        busy       = 1'b0;
        req0_ready = gnt0 & n_rst;
        req1_ready = gnt1 & n_rst;
        if (gnt0 || gnt1) begin
          shift_d      = gnt0 ? req0_data : req1_data;
          id_d         = gnt1;
          last_grant_d = gnt1;
          hit_d        = '0;
          bit_d        = '0;
          state_d      = StShift;
        end
      end
      StShift: begin
        det_i   = shift_q[WIDTH-1];
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        // det_o reflects the previous bit, so bit 0 has nothing to report yet.
        hit_inc = (bit_q != '0) & det_o;
        if (bit_q == LastBit) begin
          bit_d   = '0;
          state_d = StFlush;
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
      StFlush: begin
        hit_inc = (bit_q == '0) & det_o;
        if (bit_q == BitW'(1)) begin
          bit_d   = '0;
          state_d = StDone;
        end else begin
          bit_d = bit_q + BitW'(1);
        end
      end
      StDone: begin
        res_valid = 1'b1;
        if (res_ready) state_d = StIdle;
      end
      default: begin
        busy    = 1'b0;
        state_d = StIdle;
      end
    endcase
    if (hit_inc && (hit_q != CntMax)) hit_d = hit_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= StIdle;
      shift_q      <= '0;
      bit_q        <= '0;
      hit_q        <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_q        <= bit_d;
      hit_q        <= hit_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign res_id    = id_q;
  assign res_count = hit_q;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Bench for pattern_scan_ctrl: behavioural 1101 detector, scoreboard of expected results,
// directed latency/stall/reset/arbitration scenarios.
module tb_pattern_scan_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             n_rst;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             det_i, det_o;
  logic             res_valid, res_id, res_ready, busy;
  logic [CNT_W-1:0] res_count;

  typedef struct packed {
    logic             id;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   results_seen = 0;

  always #5 clk = ~clk;

  pattern_scan_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .det_i      (det_i),
    .det_o      (det_o),
    .res_valid  (res_valid),
    .res_id     (res_id),
    .res_count  (res_count),
    .res_ready  (res_ready),
    .busy       (busy)
  );

  // Moore 1101 detector: 0=idle 1="1" 2="11" 3="110" 4="1101" (output high)
  logic [2:0] dstate;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) dstate <= 3'd0;
    else begin
      case (dstate)
        3'd0:    dstate <= det_i ? 3'd1 : 3'd0;
        3'd1:    dstate <= det_i ? 3'd2 : 3'd0;
        3'd2:    dstate <= det_i ? 3'd2 : 3'd3;
        3'd3:    dstate <= det_i ? 3'd4 : 3'd0;
        3'd4:    dstate <= det_i ? 3'd2 : 3'd0;
        default: dstate <= 3'd0;
      endcase
    end
  end
  assign det_o = (dstate == 3'd4);

  function automatic int count_1101(input logic [WIDTH-1:0] w);
    int n = 0;
    for (int i = 0; i + 4 <= WIDTH; i++)
      if (w[WIDTH-1-i -: 4] == 4'b1101) n++;
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  // Scoreboard: push on accepted word, pop on result handshake.
  always @(negedge clk) begin
    exp_t e;
    if (n_rst) begin
      if (req0_valid && req0_ready) begin
        e.id = 1'b0; e.cnt = CNT_W'(count_1101(req0_data));
        sb.push_back(e); grant_log.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        e.id = 1'b1; e.cnt = CNT_W'(count_1101(req1_data));
        sb.push_back(e); grant_log.push_back(1);
      end
      if (res_valid && res_ready) begin
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_count", 32'(res_count), 32'(e.cnt));
        end
        results_seen++;
      end
    end
  end

  task automatic send(input logic id, input logic [WIDTH-1:0] data);
    logic got = 1'b0;
    @(posedge clk); #1;
    if (id) begin req1_valid = 1'b1; req1_data = data; end
    else begin req0_valid = 1'b1; req0_data = data; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      got = id ? req1_ready : req0_ready;
      if (got) break;
    end
    check("grant", 32'(got), 32'd1);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_results(input int target);
    for (int i = 0; i < 300 && results_seen < target; i++) @(negedge clk);
    check("results_done", 32'(results_seen >= target), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_det_i"}, 32'(det_i), 32'd0);
    check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    check({tag, "_res_id"}, 32'(res_id), 32'd0);
    check({tag, "_res_count"}, 32'(res_count), 32'd0);
    check({tag, "_req0_ready"}, 32'(req0_ready), 32'd0);
    check({tag, "_req1_ready"}, 32'(req1_ready), 32'd0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    grant_log.delete();
    n_rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [WIDTH-1:0] w;
    logic             exp_bit;
    int               base;
    n_rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_data = '0; req1_data = '0; res_ready = 1'b1;
    #2 req0_valid = 1'b1;
    #1 check_reset_outputs("rst");
    req0_valid = 1'b0;
    do_reset();

    // Latency, det_i sequence, and a held-off result with a pending request.
    base = results_seen;
    w = 8'b11011010;
    res_ready = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = w;
    @(negedge clk);
    check("ready_c0", 32'(req0_ready), 32'd1);
    check("busy_c0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= WIDTH + 2; k++) begin
      @(negedge clk);
      exp_bit = (k <= WIDTH) ? w[WIDTH-k] : 1'b0;
      check("det_i_seq", 32'(det_i), 32'(exp_bit));
      check("no_early_valid", 32'(res_valid), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      @(posedge clk); #1;
    end
    req1_valid = 1'b1; req1_data = 8'b01101101;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_id", 32'(res_id), 32'd0);
      check("stall_count", 32'(res_count), 32'(count_1101(w)));
      check("stall_r0", 32'(req0_ready), 32'd0);
      check("stall_r1", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_after_hs", 32'(busy), 32'd0);
    check("regrant_r1", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_results(base + 2);

    // Zero word and single hit.
    base = results_seen;
    send(1'b0, 8'b00000000);
    send(1'b0, 8'b11010000);
    wait_results(base + 2);

    // Round-robin with both requesters continuously valid.
    do_reset();
    base = results_seen;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_data = 8'b11011011;
    req1_valid = 1'b1; req1_data = 8'b00001101;
    for (int i = 0; i < 200 && grant_log.size() < 3; i++) @(negedge clk);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_grants", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() >= 3) begin
      check("rr_first", 32'(grant_log[0]), 32'd0);
      check("rr_second", 32'(grant_log[1]), 32'd1);
      check("rr_third", 32'(grant_log[2]), 32'd0);
    end
    wait_results(base + 3);

    // Cross-word isolation: trailing "11" must not combine with a leading "01".
    base = results_seen;
    send(1'b0, 8'b00000011);
    send(1'b0, 8'b01000000);
    wait_results(base + 2);

    // Reset during SHIFT bit 4 aborts the word.
    base = results_seen;
    send(1'b1, 8'b11011011);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    check("pre_rst_det_i", 32'(det_i), 32'd1);
    check("pre_rst_id", 32'(res_id), 32'd1);
    #1 n_rst = 1'b0;
    #1 check_reset_outputs("mid_rst");
    sb.delete();
    @(posedge clk); #1;
    n_rst = 1'b1;
    repeat (15) @(negedge clk);
    check("no_aborted_result", 32'(results_seen), 32'(base));
    send(1'b1, 8'b11011011);
    wait_results(base + 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
